// File: rtl/mic_serial_rx.sv
// Oversampling receiver for the two-wire mic serial link: assembles MSB-first words on sclk rising edges.
// Optional partial-word timeout recovery is built only when MIC_SERIAL_RX_TIMEOUT_EN is defined.
module mic_serial_rx #(
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk_in,
  input  logic                  sdi_in,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  output logic                  busy,
  output logic                  frame_error,
  output logic [15:0]           word_count
);

  localparam int CNT_W = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic                  sdi_meta_q, sdi_sync_q;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] word_out_q, word_out_d;
  logic                  word_valid_q, word_valid_d;
  logic                  frame_error_q, frame_error_d;
  logic [15:0]           word_count_q, word_count_d;
  logic                  rise, last_bit, timeout;

  // sclk flops reset high so releasing reset with sclk idle never looks like an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_meta_q <= 1'b1;
      sclk_sync_q <= 1'b1;
      sclk_prev_q <= 1'b1;
      sdi_meta_q  <= 1'b0;
      sdi_sync_q  <= 1'b0;
    end else begin
      sclk_meta_q <= sclk_in;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      sdi_meta_q  <= sdi_in;
      sdi_sync_q  <= sdi_meta_q;
    end
  end

  assign rise     = sclk_sync_q & ~sclk_prev_q;
  assign last_bit = (bit_cnt_q == CNT_W'(WORD_WIDTH - 1));

  generate
    if (WORD_WIDTH == 1) begin : g_shift_1
      assign shifted = sdi_sync_q;
    end else begin : g_shift_n
      assign shifted = {shreg_q[WORD_WIDTH-2:0], sdi_sync_q};
    end
  endgenerate

`ifdef MIC_SERIAL_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || state_q != SHIFT || rise) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
    end
  end

  // Expiry is this cycle's increment reaching TIMEOUT_CYCLES; a coincident edge wins.
  assign timeout = (state_q == SHIFT) && !rise &&
                   (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = last_bit ? DONE : SHIFT;
      SHIFT: begin
        if (rise)         state_d = last_bit ? DONE : SHIFT;
        else if (timeout) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    word_out    = word_out_q;
    word_valid  = word_valid_q;
    frame_error = frame_error_q;
    word_count  = word_count_q;
  end

  always_comb begin
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    word_out_d    = word_out_q;
    word_valid_d  = 1'b0;
    frame_error_d = timeout;
    word_count_d  = word_count_q;
    if (rise && state_q != DONE) begin
      shreg_d   = shifted;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
    if (timeout) begin
      bit_cnt_d = '0;
    end
    if (state_q == DONE) begin
      word_out_d   = shreg_q;
      word_valid_d = 1'b1;
      bit_cnt_d    = '0;
      if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      word_out_q    <= '0;
      word_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      word_count_q  <= '0;
    end else begin
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      word_out_q    <= word_out_d;
      word_valid_q  <= word_valid_d;
      frame_error_q <= frame_error_d;
      word_count_q  <= word_count_d;
    end
  end

endmodule

// File: tb/tb_mic_serial_rx.sv
// Scoreboard bench for mic_serial_rx: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_mic_serial_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk_in = 1'b1;
  logic        sdi_in = 1'b0;
  logic [31:0] word_out;
  logic        word_valid, busy, frame_error;
  logic [15:0] word_count;

  mic_serial_rx #(.WORD_WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n), .sclk_in(sclk_in), .sdi_in(sdi_in),
    .word_out(word_out), .word_valid(word_valid), .busy(busy),
    .frame_error(frame_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [15:0] count;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          ferr_seen = 0;
  int          ferr_cyc = 0;
  logic [15:0] exp_count = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (word_valid && frame_error) check("valid_ferr_exclusive", 32'd1, 32'd0);
      if (word_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_valid", word_out, 32'hxxxx_xxxx);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_out", word_out, mon_e.word);
          check("word_count", 32'(word_count), 32'(mon_e.count));
          check("busy_at_valid", 32'(busy), 32'd0);
          $display("[TB] word 0x%08h count %0d", word_out, word_count);
        end
      end
      if (frame_error) begin
        ferr_seen++;
        ferr_cyc = cyc;
        $display("[TB] frame_error at cycle %0d", cyc);
      end
    end
  end

  // Callers enter at a negedge; each bit is 4 cycles low then 4 cycles high.
  task automatic send_bits(input logic [31:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sclk_in = 1'b0;
      sdi_in  = data[31-i];
      repeat (4) @(negedge clk);
      sclk_in  = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] data);
    exp_t e;
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    e.word  = data;
    e.count = exp_count;
    exp_q.push_back(e);
    send_bits(data, 32);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
    exp_count = 16'd0;
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ferr_before;
    logic busy_seen;

    repeat (3) @(negedge clk);
    check("rst_word_out", word_out, 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    send_word(32'hDEADBEEF);
    wait_drain();
    repeat (10) @(negedge clk);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_word_out", word_out, 32'hDEADBEEF);
    check("t1_word_count", 32'(word_count), 32'd1);

    pulse_reset();
    send_word(32'h00000001);
    send_word(32'h80000000);
    wait_drain();
    check("t2_word_out", word_out, 32'h80000000);
    check("t2_word_count", 32'(word_count), 32'd2);

    pulse_reset();
    ferr_seen = 0;
    send_bits(32'hFFFFFFFF, 20);
    ferr_before = rise_cyc;
    repeat (100) @(negedge clk);
`ifdef MIC_SERIAL_RX_TIMEOUT_EN
    check("t3_ferr_pulses", 32'(ferr_seen), 32'd1);
    check("t3_ferr_latency", 32'(ferr_cyc - ferr_before), 32'd67);
    check("t3_busy_after_ferr", 32'(busy), 32'd0);
    check("t3_word_out_untouched", word_out, 32'd0);
    send_word(32'h12345678);
    wait_drain();
    check("t3_word_out", word_out, 32'h12345678);
    check("t3_word_count", 32'(word_count), 32'd1);
`else
    check("t3_no_ferr", 32'(ferr_seen), 32'd0);
    check("t3_partial_persists", 32'(busy), 32'd1);
    check("t3_word_out_untouched", word_out, 32'd0);
`endif
    pulse_reset();

    send_word(32'h0F0F0F0F);
    wait_drain();
    send_bits(32'hFFFFFFFF, 10);
    reset_n = 1'b0;
    @(negedge clk);
    check("t4_rst_word_out", word_out, 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_word_count", 32'(word_count), 32'd0);
    check("t4_rst_valid", 32'(word_valid), 32'd0);
    check("t4_rst_ferr", 32'(frame_error), 32'd0);
    reset_n   = 1'b1;
    exp_count = 16'd0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    send_word(32'hA5A5A5A5);
    wait_drain();
    check("t4_word_out", word_out, 32'hA5A5A5A5);
    check("t4_word_count", 32'(word_count), 32'd1);

    ferr_before = ferr_seen;
    busy_seen   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sdi_in = ~sdi_in;
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    repeat (5) @(negedge clk);
    check("t5_busy_never", 32'(busy_seen), 32'd0);
    check("t5_no_ferr", 32'(ferr_seen - ferr_before), 32'd0);
    check("t5_word_out_held", word_out, 32'hA5A5A5A5);

    force dut.word_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.word_count_q;
    exp_count = 16'hFFFE;
    @(negedge clk);
    check("t6_preload", 32'(word_count), 32'h0000FFFE);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    wait_drain();
    check("t6_saturated", 32'(word_count), 32'h0000FFFF);
    check("t6_word_out", word_out, 32'h33333333);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mic_serial_rx.md
# mic_serial_rx

Receiver for the two-wire microphone serial link: sclk idles high, data is MSB first, and data is stable around each sclk rising edge. Both pins are oversampled on the local clock. The block assembles WORD_WIDTH-bit words and presents each completed word with a one-cycle valid strobe. It sits at the far end of the mic serial link, on the board that consumes the words the ceiling controller shifts out, and feeds that board's register map.

## Interface
Parameters:
- WORD_WIDTH, 32, bits per word; MSB received first.
- TIMEOUT_CYCLES, 64, clk cycles without an sclk rising edge, while mid-word, before the partial word is discarded.

Ports:
- clk  input  1  system clock; everything is synchronous to it.
- reset_n  input  1  synchronous, active-low reset.
- sclk_in  input  1  serial clock from the link; asynchronous to clk; idles high.
- sdi_in  input  1  serial data from the link; asynchronous to clk.
- word_out  output  WORD_WIDTH  last complete word received; held until the next complete word.
- word_valid  output  1  one-cycle pulse when word_out updates.
- busy  output  1  high while a word is partially received.
- frame_error  output  1  one-cycle pulse when a partial word is discarded by timeout.
- word_count  output  16  number of completed words; saturates at 0xFFFF.

## Operation
- Input synchronization:
  - sclk_in and sdi_in each pass through a 2-flop synchronizer of identical depth, so the two stay aligned.
  - A third register on the synchronized sclk provides rising-edge detection (previous 0, current 1).
- Rising-edge sampling: on each detected rising edge, the synchronized sdi shifts into the LSB of an internal shift register (shreg <= {shreg[WORD_WIDTH-2:0], sdi}), and bit_cnt increments.
- bit_cnt width is $clog2(WORD_WIDTH+1).
- State machine:
  - IDLE: bit_cnt=0, busy=0. A rising edge samples bit 0, sets bit_cnt=1 and moves to SHIFT. When WORD_WIDTH=1 it goes straight to word completion.
  - SHIFT: busy=1. Each rising edge samples one bit.
  - Word completion: on the rising edge that makes bit_cnt reach WORD_WIDTH:
    - the next cycle, word_out <= assembled word, word_valid=1, and word_count increments unless it is 0xFFFF;
    - the state returns to IDLE with bit_cnt=0.
  - Timeout (only when MIC_SERIAL_RX_TIMEOUT_EN is defined):
    - In SHIFT, idle_cnt counts clk cycles since the last rising edge.
    - When idle_cnt reaches TIMEOUT_CYCLES with no edge in that cycle: pulse frame_error, clear bit_cnt, go to IDLE.
    - An edge in the same cycle as expiry wins: the bit is sampled and idle_cnt clears.
- Partial words never modify word_out.
- Falling edges and sdi activity while sclk is static are ignored.
- Reset (reset_n low at any clock edge, including mid-word):
  - state=IDLE, bit_cnt=0, idle_cnt=0, shreg=0;
  - word_out=0, word_valid=0, busy=0, frame_error=0, word_count=0;
  - synchronizer flops reset to 1 for sclk and 0 for sdi, so no false edge is seen on release.

## Timing
- Edge detect latency: a pin rising edge becomes a detected edge 3 clk cycles later (2 synchronizer flops plus the edge register).
- word_valid asserts 1 cycle after the final detected edge, i.e. 4 clk cycles after the final pin rising edge.
- sclk high and low phases must each be ≥3 clk cycles; the transmitter uses 4 cycles per phase at the same clock rate.
- sdi must be stable from 1 cycle before to 2 cycles after each sclk rising edge, measured at the pins.
- Back-to-back words need no gap: the first rising edge of the next word may follow the last edge of the previous word by a single sclk period.
- word_valid and frame_error are never high in the same cycle. They are mutually exclusive by construction: timeout only fires with bit_cnt < WORD_WIDTH.
- busy deasserts in the same cycle that word_valid or frame_error asserts.

## Configuration
- MIC_SERIAL_RX_TIMEOUT_EN defined:
  - idle_cnt (width $clog2(TIMEOUT_CYCLES+1)) and timeout recovery are built in;
  - frame_error behaves as in Operation.
- MIC_SERIAL_RX_TIMEOUT_EN undefined:
  - no idle_cnt logic;
  - frame_error is tied 0;
  - a partial word persists indefinitely in SHIFT, and realignment is possible only through reset_n.

## Test plan
- Send 0xDEADBEEF with 4-cycle half periods, sclk idle high before and after -> exactly one word_valid pulse; word_out=0xDEADBEEF; word_count=1; busy low afterwards.
- Send 0x00000001, then 0x80000000 with the first rising edge of the second word one sclk period after the last edge of the first -> two word_valid pulses; word_out=0x80000000 after the second pulse; word_count=2.
- (TIMEOUT_EN) Send the top 20 bits of 0xFFFFFFFF, hold sclk high for 100 cycles, then send 0x12345678 -> frame_error pulses 64 cycles after the 20th detected edge; no word_valid for the partial; word_out=0x12345678 after the next word; word_count=1.
- Drive reset_n low for 1 cycle after 10 bits of a word, then send 0xA5A5A5A5 -> all outputs return to reset values; one word_valid pulse; word_out=0xA5A5A5A5; word_count=1.
- Hold sclk high and toggle sdi every cycle for 200 cycles -> busy, word_valid and frame_error stay 0; word_out is unchanged.
- Preload word_count to 0xFFFE (force or 65534 words) and send 3 words -> word_count reads 0xFFFF and stays there; word_valid still pulses for each word.
